// File: rtl/bcd_alu_seq_if.sv
// Start/busy/done handshake and operand/result bus for the sequential BCD ALU.
// The bench (master) drives the request side; the ALU (slave) drives status and result.
interface bcd_alu_seq_if #(
  parameter int DIGITS = 2
);
  logic                  start;
  logic [1:0]            op;
  logic [4*DIGITS-1:0]   a_bcd;
  logic [4*DIGITS-1:0]   b_bcd;
  logic                  busy;
  logic                  done;
  logic [8*DIGITS-1:0]   result;
  logic                  neg;
  logic                  error;

  modport master (
    output start, op, a_bcd, b_bcd,
    input  busy, done, result, neg, error
  );

  modport slave (
    input  start, op, a_bcd, b_bcd,
    output busy, done, result, neg, error
  );
endinterface

// File: rtl/bcd_alu_seq.sv
// Multi-cycle BCD ALU: BCD->binary, add/sub/shift-add mul/restoring div with round-half-up,
// then double-dabble back to a 2*DIGITS-digit BCD magnitude.
module bcd_alu_seq #(
  parameter int DIGITS = 2
) (
  input logic          clk,
  input logic          rst,
  bcd_alu_seq_if.slave bus
);
  localparam int BW = 4 * DIGITS;
  localparam int PW = 2 * BW;
  localparam int CW = $clog2(PW + 1);

  typedef enum logic [2:0] {S_IDLE, S_CONV, S_EXEC, S_B2B, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_done, r_neg_o, r_err_o;
  logic [PW-1:0] r_result;

  logic [1:0]    r_op;
  logic [BW-1:0] r_a_sh, r_b_sh, r_y, r_rem;
  logic [PW-1:0] r_x, r_acc, r_bcd;
  logic          r_inv, r_err, r_neg;

  logic [3:0]         w_a_dig, w_b_dig;
  logic [BW-1:0]      w_a_acc, w_b_acc;
  logic               w_inv_nxt, w_conv_last, w_err_det, w_exec_last, w_accept;
  logic [BW:0]        w_rem_sh, w_trial;
  logic signed [BW:0] w_diff, w_mag;
  logic [PW-1:0]      w_adj;

  function automatic logic [PW-1:0] dd_adjust(input logic [PW-1:0] v);
    logic [PW-1:0] r;
    r = v;
    for (int i = 0; i < PW / 4; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] round_half_up(input logic [BW-1:0] q,
                                                  input logic [BW-1:0] rem,
                                                  input logic [BW-1:0] dv);
    return PW'(q) + PW'({rem, 1'b0} >= {1'b0, dv});
  endfunction

  assign w_a_dig     = r_a_sh[BW-1 -: 4];
  assign w_b_dig     = r_b_sh[BW-1 -: 4];
  assign w_a_acc     = r_x[BW-1:0] * BW'(10) + BW'(w_a_dig);
  assign w_b_acc     = r_y * BW'(10) + BW'(w_b_dig);
  assign w_inv_nxt   = r_inv | (w_a_dig > 4'd9) | (w_b_dig > 4'd9);
  assign w_conv_last = (r_cnt == CW'(DIGITS - 1));
  assign w_err_det   = w_inv_nxt || ((r_op == 2'b11) && (w_b_acc == '0));
  assign w_accept    = (r_state == S_IDLE) && bus.start && !r_done;
  // Restoring-divide trial: {rem, next dividend bit} minus divisor; MSB set means restore.
  assign w_rem_sh    = {r_rem, r_y[BW-1]};
  assign w_trial     = w_rem_sh - {1'b0, r_x[BW-1:0]};
  assign w_diff      = $signed({1'b0, r_x[BW-1:0]}) - $signed({1'b0, r_y});
  assign w_mag       = w_diff[BW] ? -w_diff : w_diff;
  assign w_adj       = dd_adjust(r_bcd);

  always_comb begin
    w_exec_last = 1'b0;
    case (r_op)
      2'b10:   w_exec_last = (r_cnt == CW'(BW - 1));
      2'b11:   w_exec_last = (r_cnt == CW'(BW));
      default: w_exec_last = (r_cnt == '0);
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_CONV;
      S_CONV:  if (w_conv_last) w_state_nxt = w_err_det ? S_DONE : S_EXEC;
      S_EXEC:  if (w_exec_last) w_state_nxt = S_B2B;
      S_B2B:   if (r_cnt == CW'(PW - 1)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_neg_o  <= 1'b0;
      r_err_o  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (w_state_nxt != r_state || r_state == S_IDLE) ? '0 : r_cnt + CW'(1);
      r_done  <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        r_result <= r_err ? '0 : r_bcd;
        r_neg_o  <= r_neg & ~r_err;
        r_err_o  <= r_err;
      end
    end
  end

  // Working datapath; every field is re-initialised on start acceptance.
  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          r_op   <= bus.op;
          r_a_sh <= bus.a_bcd;
          r_b_sh <= bus.b_bcd;
          r_x    <= '0;
          r_y    <= '0;
          r_acc  <= '0;
          r_bcd  <= '0;
          r_rem  <= '0;
          r_inv  <= 1'b0;
          r_err  <= 1'b0;
          r_neg  <= 1'b0;
        end
      end
      S_CONV: begin
        r_a_sh <= r_a_sh << 4;
        r_b_sh <= r_b_sh << 4;
        r_inv  <= w_inv_nxt;
        if (w_conv_last && r_op == 2'b11) begin
          r_x <= PW'(w_b_acc);
          r_y <= w_a_acc;
        end else begin
          r_x <= PW'(w_a_acc);
          r_y <= w_b_acc;
        end
        if (w_conv_last) r_err <= w_err_det;
      end
      S_EXEC: begin
        case (r_op)
          2'b00: r_acc <= PW'(r_x[BW-1:0]) + PW'(r_y);
          2'b01: begin
            r_acc <= PW'($unsigned(w_mag));
            r_neg <= w_diff[BW];
          end
          2'b10: begin
            if (r_y[0]) r_acc <= r_acc + r_x;
            r_x <= r_x << 1;
            r_y <= r_y >> 1;
          end
          default: begin
            if (r_cnt == CW'(BW)) begin
              r_acc <= round_half_up(r_y, r_rem, r_x[BW-1:0]);
            end else if (!w_trial[BW]) begin
              r_rem <= w_trial[BW-1:0];
              r_y   <= {r_y[BW-2:0], 1'b1};
            end else begin
              r_rem <= w_rem_sh[BW-1:0];
              r_y   <= {r_y[BW-2:0], 1'b0};
            end
          end
        endcase
      end
      S_B2B:   {r_bcd, r_acc} <= {w_adj, r_acc} << 1;
      default: ;
    endcase
  end

  assign bus.busy   = (r_state != S_IDLE) | r_done;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.neg    = r_neg_o;
  assign bus.error  = r_err_o;
endmodule

// File: tb/tb_bcd_alu_seq.sv
// Directed and randomized checks of bcd_alu_seq (DIGITS=2) against a decimal reference model.
module tb_bcd_alu_seq;
  localparam int D  = 2;
  localparam int BW = 4 * D;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_fail;

  bcd_alu_seq_if #(.DIGITS(D)) bus ();

  bcd_alu_seq #(.DIGITS(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal reference: operate on integer values, then spell the result out in decimal digits.
  task automatic model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] res, output logic ng, output logic er,
                       output int lat);
    int av, bv, r, e;
    bit inv;
    inv = 1'b0; av = 0; bv = 0; r = 0; ng = 1'b0; er = 1'b0; e = 1;
    for (int i = D - 1; i >= 0; i--) begin
      if (a[4*i +: 4] > 9 || b[4*i +: 4] > 9) inv = 1'b1;
      av = av * 10 + int'(a[4*i +: 4]);
      bv = bv * 10 + int'(b[4*i +: 4]);
    end
    if (inv || (op == 2'b11 && bv == 0)) begin
      er = 1'b1;
      lat = D + 1;
    end else begin
      case (op)
        2'b00: r = av + bv;
        2'b01: begin
          r  = (av >= bv) ? av - bv : bv - av;
          ng = (bv > av);
        end
        2'b10: begin r = av * bv; e = BW; end
        default: begin
          r = av / bv;
          if (2 * (av % bv) >= bv) r = r + 1;
          e = BW + 1;
        end
      endcase
      lat = D + e + 2 * BW + 1;
    end
    res = '0;
    for (int i = 0; i < 2 * D; i++) begin
      res[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
  endtask

  task automatic run(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                     input string tag);
    logic [15:0] eres;
    logic        eneg, eerr;
    int          elat, n;
    model(op, a, b, eres, eneg, eerr, elat);
    @(negedge clk);
    bus.op = op; bus.a_bcd = a; bus.b_bcd = b; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 2'($urandom);
    bus.a_bcd = 8'($urandom);
    bus.b_bcd = 8'($urandom);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!bus.done && n < 100);
    chk({tag, " latency"}, 32'(n), 32'(elat));
    chk({tag, " result"}, 32'(bus.result), 32'(eres));
    chk({tag, " neg"}, 32'(bus.neg), 32'(eneg));
    chk({tag, " error"}, 32'(bus.error), 32'(eerr));
    chk({tag, " busy@done"}, 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk({tag, " done pulse"}, 32'(bus.done), 32'd0);
    chk({tag, " hold"}, 32'(bus.result), 32'(eres));
  endtask

  function automatic logic [7:0] gen_bcd(input bit bad);
    logic [7:0] v;
    v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    if (bad) begin
      if ($urandom_range(0, 1) == 0) v[7:4] = 4'($urandom_range(10, 15));
      else                           v[3:0] = 4'($urandom_range(10, 15));
    end
    return v;
  endfunction

  initial begin
    int ndone;
    logic [15:0] cap;
    n_vec = 0; n_fail = 0; ndone = 0; cap = '0;
    rst = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.a_bcd = '0; bus.b_bcd = '0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset result", 32'(bus.result), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset neg", 32'(bus.neg), 32'd0);
    chk("reset error", 32'(bus.error), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run(2'b00, 8'h99, 8'h99, "add 99+99");
    run(2'b01, 8'h12, 8'h47, "sub 12-47");
    run(2'b01, 8'h47, 8'h47, "sub 47-47");
    run(2'b10, 8'h99, 8'h99, "mul 99*99");
    run(2'b10, 8'h00, 8'h57, "mul 00*57");
    run(2'b11, 8'h17, 8'h04, "div 17/4");
    run(2'b11, 8'h18, 8'h04, "div 18/4");
    run(2'b11, 8'h99, 8'h01, "div 99/1");
    run(2'b11, 8'h05, 8'h00, "div 05/00");
    run(2'b00, 8'h1A, 8'h03, "add bad nibble");
    run(2'b11, 8'h99, 8'h01, "div 99/1 again");

    // Reset in the middle of a multiply: outputs clear at once and no done follows.
    @(negedge clk);
    bus.op = 2'b10; bus.a_bcd = 8'h34; bus.b_bcd = 8'h56; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midreset result", 32'(bus.result), 32'd0);
    chk("midreset busy", 32'(bus.busy), 32'd0);
    chk("midreset done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("midreset no done", 32'(ndone), 32'd0);
    run(2'b10, 8'h34, 8'h56, "mul after reset");

    // Extra start pulses while busy must be ignored.
    @(negedge clk);
    bus.op = 2'b00; bus.a_bcd = 8'h25; bus.b_bcd = 8'h31; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    ndone = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        cap = bus.result;
      end
      bus.start = (c == 4 || c == 11);
      bus.op    = 2'b10;
      bus.a_bcd = 8'h77;
    end
    bus.start = 1'b0;
    chk("busy start one done", 32'(ndone), 32'd1);
    chk("busy start result", 32'(cap), 32'h0056);

    for (int k = 0; k < 30; k++) begin
      logic [1:0] op;
      logic [7:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = gen_bcd($urandom_range(0, 9) == 0);
      b  = gen_bcd($urandom_range(0, 9) == 0);
      if (op == 2'b11 && $urandom_range(0, 7) == 0) b = 8'h00;
      run(op, a, b, $sformatf("rand%0d op%0d %h,%h", k, op, a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
